// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define PARITY_EN to compile in the parity state and insert the parity bit before the stop bit.
module serial_frame_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             TXD,
  output logic             TXD_N,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IMAX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_next;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
`ifdef PARITY_EN
  logic             r_parity;
  logic             w_parity_next;
`endif
  logic             w_bit_end;

  logic             r_txd;
  logic             r_txd_n;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_txd_next;
  logic             w_ready_next;
  logic             w_busy_next;
  logic             w_done_next;

  assign w_bit_end = (r_timer == TMAX);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; VALID only matters in IDLE, where READY is high
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (VALID) w_state_next = S_START;
      S_START:  if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_idx == IMAX)) begin
`ifdef PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`endif
      S_STOP:   if (w_bit_end) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Bit timer, bit index and shift register next values
  always_comb begin
    w_timer_next  = r_timer;
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
`ifdef PARITY_EN
    w_parity_next = r_parity;
`endif
    if (r_state == S_IDLE) begin
      w_timer_next = '0;
      w_idx_next   = '0;
      if (VALID) begin
        w_shift_next  = DATA;
`ifdef PARITY_EN
        w_parity_next = ^DATA;
`endif
      end
    end else if (w_bit_end) begin
      w_timer_next = '0;
      if (r_state == S_DATA) begin
        w_shift_next = r_shift >> 1;
        w_idx_next   = (r_idx == IMAX) ? '0 : r_idx + IW'(1);
      end
    end else begin
      w_timer_next = r_timer + TW'(1);
    end
  end

  // Output decode from the upcoming state so the registered line leads with no extra delay
  always_comb begin
    w_txd_next   = 1'b1;
    w_ready_next = 1'b0;
    w_busy_next  = 1'b1;
    case (w_state_next)
      S_IDLE: begin
        w_ready_next = 1'b1;
        w_busy_next  = 1'b0;
      end
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = w_shift_next[0];
`ifdef PARITY_EN
      S_PARITY: w_txd_next = w_parity_next;
`endif
      S_STOP:   w_txd_next = 1'b1;
      default:  w_txd_next = 1'b1;
    endcase
    w_done_next = (r_state == S_STOP) && (w_state_next == S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_timer  <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
`ifdef PARITY_EN
      r_parity <= 1'b0;
`endif
      r_txd    <= 1'b1;
      r_txd_n  <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_timer  <= w_timer_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
`ifdef PARITY_EN
      r_parity <= w_parity_next;
`endif
      r_txd    <= w_txd_next;
      r_txd_n  <= ~w_txd_next;
      r_ready  <= w_ready_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  assign TXD   = r_txd;
  assign TXD_N = r_txd_n;
  assign READY = r_ready;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule
